// File: rtl/branch_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl_if
// Bundle of signals between the pipeline and the ID-stage hazard controller.
//   master : pipeline side. It drives the ID/EX/MEM descriptors and mem_busy,
//            and it receives stall/bubble/flush/freeze and the perf counters.
//   slave  : hazard controller side. The directions are the reverse of master.
// Parameters:
//   REG_AW : register-address width.
//   CNT_W  : performance-counter width.
// ---------------------------------------------------------------------------
interface branch_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_branch;
  logic              id_mispredict;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_memread;
  logic              mem_busy;
  logic              stall;
  logic              bubble;
  logic              flush;
  logic              freeze;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch,
           id_mispredict, ex_rd, ex_regwrite, ex_memread, mem_rd,
           mem_regwrite, mem_memread, mem_busy,
    input  stall, bubble, flush, freeze, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch,
           id_mispredict, ex_rd, ex_regwrite, ex_memread, mem_rd,
           mem_regwrite, mem_memread, mem_busy,
    output stall, bubble, flush, freeze, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
// ID-stage hazard controller for a pipeline that resolves branches early in
// ID. It finds RAW hazards of the ID instruction against EX and MEM
// producers. It issues stalls of one or more cycles through a small counter
// FSM. It flushes IF/ID on a branch mispredict, and it freezes the whole pipe
// while data memory is busy. It also keeps saturating stall and flush
// counters.
// Ports:
//   clk : rising-edge clock.
//   rst : asynchronous reset, active-high.
//   bus : branch_hazard_ctrl_if.slave. Inputs are the ID/EX/MEM descriptors
//         and mem_busy. Outputs are stall, bubble, flush, freeze, stall_cnt
//         and flush_cnt.
// Parameters:
//   REG_AW  : register-address width.
//   STALL_W : width of the pending-stall counter. It must be >= 2.
//   CNT_W   : performance-counter width. It must match the interface.
//   FWD_ID  : 1 when an EX/MEM->ID forwarding path exists.
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int STALL_W = 2,
  parameter int CNT_W   = 16,
  parameter int FWD_ID  = 1
) (
  input logic               clk,
  input logic               rst,
  branch_hazard_ctrl_if.slave bus
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t             state_q, state_d;
  logic [STALL_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               ex_hit, mem_hit;
  logic               ex_load, ex_alu, mem_load, mem_alu;
  logic [STALL_W-1:0] need;
  logic               stall, bubble, flush, freeze;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard detection. Register x0 is never a producer.
  always_comb begin
    ex_hit  = bus.id_valid && (bus.ex_rd != '0) &&
              ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
               (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    mem_hit = bus.id_valid && (bus.mem_rd != '0) &&
              ((bus.id_use_rs1 && (bus.id_rs1 == bus.mem_rd)) ||
               (bus.id_use_rs2 && (bus.id_rs2 == bus.mem_rd)));
    ex_load  = ex_hit  && bus.ex_memread;
    ex_alu   = ex_hit  && bus.ex_regwrite && !bus.ex_memread;
    mem_load = mem_hit && bus.mem_memread;
    mem_alu  = mem_hit && bus.mem_regwrite && !bus.mem_memread;
  end

  // Stall cycles required before the ID instruction can proceed. An EX
  // producer shadows any MEM producer of the same operand set.
  always_comb begin
    need = '0;
    if (bus.id_valid && bus.id_branch) begin
      if (FWD_ID != 0) begin
        if (ex_load)       need = STALL_W'(2);
        else if (ex_alu)   need = STALL_W'(1);
        else if (mem_load) need = STALL_W'(1);
      end else begin
        if (ex_load || ex_alu)        need = STALL_W'(2);
        else if (mem_load || mem_alu) need = STALL_W'(1);
      end
    end else if (ex_load) begin
      need = STALL_W'(1);
    end
  end

  // FSM next state and outputs. The first bubble comes out in the detect
  // cycle. rem then counts the bubbles that are still owed.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    freeze  = 1'b0;
    if (rst) begin
      // Keep the outputs quiet while reset is held.
    end else if (bus.mem_busy) begin
      freeze = 1'b1;
      stall  = 1'b1;
    end else if (state_q == STALL) begin
      stall  = 1'b1;
      bubble = 1'b1;
      rem_d  = rem_q - STALL_W'(1);
      if (rem_q == STALL_W'(1)) state_d = IDLE;
    end else if (need != '0) begin
      stall  = 1'b1;
      bubble = 1'b1;
      if (need > STALL_W'(1)) begin
        rem_d   = need - STALL_W'(1);
        state_d = STALL;
      end
    end else begin
      flush = bus.id_valid && bus.id_branch && bus.id_mispredict;
    end
  end

  // Performance counters. During a freeze, bubble and flush are both 0, so
  // the counters hold.
  always_comb begin
    stall_cnt_d = bubble ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush  ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.bubble    = bubble;
  assign bus.flush     = flush;
  assign bus.freeze    = freeze;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
